// File: rtl/tgfx_sd_pkg.sv
// rtl/tgfx_sd_pkg.sv - shared types and constants for the sector responder
package tgfx_sd_pkg;

    localparam int SECTOR_WORDS = 256;
    localparam int SECTOR_BYTES = 512;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_PUT,
        WR_ADDR,
        WR_CAP,
        WR_STORE,
        DONE
    } sd_state_e;

endpackage

// File: rtl/sd_mount_ctl.sv
// rtl/sd_mount_ctl.sv - mount edge detect, image latches and sector range check
module sd_mount_ctl
    import tgfx_sd_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        mount_req,
    input  logic [63:0] mount_size,
    input  logic        mount_ro,
    input  logic [31:0] lba,
    output logic        img_mounted,
    output logic [63:0] img_size,
    output logic        img_readonly,
    output logic        lba_ok
);

    localparam int BYTE_SHIFT = $clog2(SECTOR_BYTES);

    logic        req_q;
    logic        mounted_q;
    logic [63:0] size_q;
    logic        ro_q;
    logic        rise;

    assign rise = mount_req & ~req_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= 1'b0;
            mounted_q <= 1'b0;
            size_q    <= 64'd0;
            ro_q      <= 1'b0;
        end else begin
            req_q     <= mount_req;
            mounted_q <= rise;
            if (rise) begin
                size_q <= mount_size;
                ro_q   <= mount_ro;
            end
        end
    end

    assign img_mounted  = mounted_q;
    assign img_size     = size_q;
    assign img_readonly = ro_q;

    // An empty image (size 0) fails the first term, so no separate mounted flag is needed.
    assign lba_ok = (64'(lba) < (size_q >> BYTE_SHIFT)) && ((lba >> (ADDR_W - 8)) == 32'd0);

endmodule

// File: rtl/sd_sector_responder.sv
// rtl/sd_sector_responder.sv - device-side sector server between core buffer and word store
module sd_sector_responder
    import tgfx_sd_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int ST_TMO = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [7:0]        sd_buff_addr,
    output logic [15:0]       sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [15:0]       sd_buff_din,
    input  logic              mount_req,
    input  logic [63:0]       mount_size,
    input  logic              mount_ro,
    output logic              img_mounted,
    output logic [63:0]       img_size,
    output logic              img_readonly,
    output logic [ADDR_W-1:0] st_addr,
    output logic              st_rd,
    output logic              st_wr,
    output logic [15:0]       st_din,
    input  logic [15:0]       st_dout,
    input  logic              st_ack
);

    localparam int         LBA_W    = ADDR_W - 8;
    localparam int         TMO_W    = 16;
    localparam logic [7:0] LAST_IDX = 8'(SECTOR_WORDS - 1);

    sd_state_e        state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [7:0]       addr_hold_q, addr_hold_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic             ok_q, ok_d;
    logic [15:0]      data_q, data_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             hold_q, hold_d;
    logic             lba_ok;
    logic             tmo_expired;

    sd_mount_ctl #(.ADDR_W(ADDR_W)) u_mount (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .mount_req    (mount_req),
        .mount_size   (mount_size),
        .mount_ro     (mount_ro),
        .lba          (sd_lba),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .lba_ok       (lba_ok)
    );

    assign tmo_expired  = (ST_TMO != 0) && (tmo_q == TMO_W'(ST_TMO - 1));
    assign st_addr      = {lba_q, idx_q};
    assign st_din       = data_q;
    assign sd_buff_dout = data_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= 8'd0;
            addr_hold_q <= 8'd0;
            lba_q       <= '0;
            ok_q        <= 1'b0;
            data_q      <= 16'd0;
            tmo_q       <= '0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_hold_q <= addr_hold_d;
            lba_q       <= lba_d;
            ok_q        <= ok_d;
            data_q      <= data_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_hold_d  = addr_hold_q;
        lba_d        = lba_q;
        ok_d         = ok_q;
        data_d       = data_q;
        tmo_d        = '0;
        hold_d       = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        sd_buff_addr = addr_hold_q;
        st_rd        = 1'b0;
        st_wr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hold_q && (sd_rd || sd_wr)) begin
                    lba_d   = sd_lba[LBA_W-1:0];
                    idx_d   = 8'd0;
                    ok_d    = lba_ok && (sd_rd || !img_readonly);
                    state_d = sd_rd ? RD_FETCH : WR_ADDR;
                end
            end
            RD_FETCH: begin
                sd_ack = 1'b1;
                if (!ok_q) begin
                    data_d  = 16'd0;
                    state_d = RD_PUT;
                end else begin
                    st_rd = 1'b1;
                    if (st_ack) begin
                        data_d  = st_dout;
                        state_d = RD_PUT;
                    end else if (tmo_expired) begin
                        data_d  = 16'd0;
                        state_d = RD_PUT;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            RD_PUT: begin
                sd_ack       = 1'b1;
                sd_buff_wr   = 1'b1;
                sd_buff_addr = idx_q;
                addr_hold_d  = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD_FETCH;
                end
            end
            WR_ADDR: begin
                sd_ack       = 1'b1;
                sd_buff_addr = idx_q;
                addr_hold_d  = idx_q;
                state_d      = WR_CAP;
            end
            WR_CAP: begin
                sd_ack  = 1'b1;
                data_d  = sd_buff_din;
                state_d = WR_STORE;
            end
            WR_STORE: begin
                sd_ack = 1'b1;
                st_wr  = ok_q;
                // Discarded writes and timed-out store writes advance just like acked ones.
                if (!ok_q || st_ack || tmo_expired) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = WR_ADDR;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                hold_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sd_sector_responder.sv
// tb/tb_sd_sector_responder.sv - directed bench for the sector responder
module tb_sd_sector_responder;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = 32'd0;
    logic        sd_rd = 1'b0;
    logic        sd_wr = 1'b0;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din = 16'd0;
    logic        mount_req = 1'b0;
    logic [63:0] mount_size = 64'd0;
    logic        mount_ro = 1'b0;
    logic        img_mounted;
    logic [63:0] img_size;
    logic        img_readonly;
    logic [11:0] st_addr;
    logic        st_rd;
    logic        st_wr;
    logic [15:0] st_din;
    logic [15:0] st_dout;
    logic        st_ack;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [15:0] wbuf    [0:255];
    logic        ack_en = 1'b1;
    logic        mem_init = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int cap_n = 0, bad_n = 0, stw_n = 0, str_n = 0, chg_n = 0, rise_n = 0, gap_viol = 0, low_cnt = 0;
    int cap_base = 0;
    logic [31:0] exp_lba = 32'd0;
    logic        exp_zero = 1'b0;
    logic [7:0]  addr_prev = 8'd0;
    logic        ack_prev = 1'b0;
    int d_cap, d_bad, d_stw, d_str, d_chg;

    always #5 clk_sys = ~clk_sys;

    sd_sector_responder #(.ADDR_W(12), .ST_TMO(4)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mount_req    (mount_req),
        .mount_size   (mount_size),
        .mount_ro     (mount_ro),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .st_addr      (st_addr),
        .st_rd        (st_rd),
        .st_wr        (st_wr),
        .st_din       (st_din),
        .st_dout      (st_dout),
        .st_ack       (st_ack)
    );

    assign st_ack  = ack_en && (st_rd || st_wr);
    assign st_dout = mem[st_addr];

    // Store, core buffer and bus monitor; counters only ever increase.
    always @(negedge clk_sys) begin
        logic [7:0]  ea;
        logic [15:0] ed;
        if (!mem_init) begin
            for (int a = 0; a < 4096; a++) mem[a] = 16'(a) ^ 16'hA5A5;
            mem_init = 1'b1;
        end
        if (st_wr && st_ack) begin
            mem[st_addr] = st_din;
            stw_n++;
        end
        if (st_rd) str_n++;
        if (sd_buff_wr) begin
            ea = 8'(cap_n - cap_base);
            ed = exp_zero ? 16'h0000 : ref_mem[{exp_lba[3:0], ea}];
            if (sd_buff_addr !== ea || sd_buff_dout !== ed) bad_n++;
            cap_n++;
        end
        if (sd_ack && sd_buff_addr !== addr_prev) chg_n++;
        sd_buff_din = wbuf[addr_prev];
        addr_prev   = sd_buff_addr;
        if (sd_ack && !ack_prev) begin
            rise_n++;
            if (low_cnt < 3) gap_viol++;
        end
        low_cnt  = sd_ack ? 0 : low_cnt + 1;
        ack_prev = sd_ack;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mount(input logic [63:0] size, input logic ro);
        @(negedge clk_sys);
        mount_size = size;
        mount_ro   = ro;
        mount_req  = 1'b1;
        @(negedge clk_sys);
        check("img_mounted_hi", img_mounted, 1);
        mount_req = 1'b0;
        @(negedge clk_sys);
        check("img_mounted_lo", img_mounted, 0);
        check("img_size", img_size, size);
        check("img_readonly", img_readonly, ro);
    endtask

    task automatic do_xfer(input logic rd, input logic [31:0] lba, input logic zero);
        int b_cap, b_bad, b_stw, b_str, b_chg, n;
        b_cap = cap_n; b_bad = bad_n; b_stw = stw_n; b_str = str_n; b_chg = chg_n;
        exp_lba  = lba;
        exp_zero = zero;
        cap_base = cap_n;
        @(negedge clk_sys);
        sd_lba = lba;
        if (rd) sd_rd = 1'b1; else sd_wr = 1'b1;
        n = 0;
        while (!sd_ack && n < 20) begin @(negedge clk_sys); n++; end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        check("ack_rise", sd_ack, 1);
        n = 0;
        while (sd_ack && n < 4000) begin @(negedge clk_sys); n++; end
        check("ack_fall", sd_ack, 0);
        d_cap = cap_n - b_cap; d_bad = bad_n - b_bad; d_stw = stw_n - b_stw;
        d_str = str_n - b_str; d_chg = chg_n - b_chg;
    endtask

    initial begin
        int bad, tot_cap, tot_bad, rb, gb, n;
        for (int a = 0; a < 4096; a++) ref_mem[a] = 16'(a) ^ 16'hA5A5;
        for (int i = 0; i < 256; i++) wbuf[i] = 16'(i * 3);

        repeat (3) @(negedge clk_sys);
        check("rst_ack", sd_ack, 0);
        check("rst_img_size", img_size, 0);
        check("rst_st_addr", st_addr, 0);
        reset_n = 1'b1;

        mount(64'd8192, 1'b0);
        do_xfer(1'b1, 32'd3, 1'b0);
        check("rd3_strobes", d_cap, 256);
        check("rd3_data", d_bad, 0);
        check("rd3_st_rd", d_str, 256);

        do_xfer(1'b0, 32'd2, 1'b0);
        for (int i = 0; i < 256; i++) ref_mem[512 + i] = 16'(i * 3);
        check("wr2_st_wr", d_stw, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[512 + i] !== 16'(i * 3)) bad++;
        check("wr2_store", bad, 0);
        check("wr2_neighbours", {mem[511], mem[768]}, {16'h01FF ^ 16'hA5A5, 16'h0300 ^ 16'hA5A5});
        do_xfer(1'b1, 32'd2, 1'b0);
        check("rb2_data", d_bad, 0);
        check("rb2_strobes", d_cap, 256);

        mount(64'd8192, 1'b1);
        for (int i = 0; i < 256; i++) wbuf[i] = ~16'(i);
        do_xfer(1'b0, 32'd1, 1'b0);
        check("ro_st_wr", d_stw, 0);
        check("ro_addr_steps", d_chg, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[256 + i] !== (16'(256 + i) ^ 16'hA5A5)) bad++;
        check("ro_store", bad, 0);
        do_xfer(1'b1, 32'd1, 1'b0);
        check("ro_read", d_bad, 0);

        mount(64'd8192, 1'b0);
        do_xfer(1'b1, 32'd16, 1'b1);
        check("oor_strobes", d_cap, 256);
        check("oor_zero", d_bad, 0);
        check("oor_st_rd", d_str, 0);
        mount(64'd0, 1'b0);
        do_xfer(1'b1, 32'd0, 1'b1);
        check("nomnt_zero", d_bad, 0);
        check("nomnt_st_rd", d_str, 0);

        mount(64'd8192, 1'b0);
        rb = rise_n; gb = gap_viol; tot_cap = 0; tot_bad = 0;
        for (int l = 0; l < 16; l++) begin
            do_xfer(1'b1, 32'(l), 1'b0);
            tot_cap += d_cap;
            tot_bad += d_bad;
        end
        check("loop_xfers", rise_n - rb, 16);
        check("loop_strobes", tot_cap, 4096);
        check("loop_data", tot_bad, 0);
        check("loop_ack_gap", gap_viol - gb, 0);

        exp_lba = 32'd3; exp_zero = 1'b0; cap_base = cap_n;
        @(negedge clk_sys);
        sd_lba = 32'd3;
        sd_rd  = 1'b1;
        n = 0;
        while (!sd_ack && n < 20) begin @(negedge clk_sys); n++; end
        sd_rd = 1'b0;
        n = 0;
        while ((cap_n - cap_base) < 100 && n < 1000) begin @(negedge clk_sys); n++; end
        check("rst_mid_word", cap_n - cap_base, 100);
        #2 reset_n = 1'b0;
        #1;
        check("arst_ack", sd_ack, 0);
        check("arst_outs", {sd_buff_wr, st_rd, st_wr, img_mounted, img_readonly}, 0);
        check("arst_addr", {sd_buff_addr, st_addr, sd_buff_dout, st_din}, 0);
        check("arst_img_size", img_size, 0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;

        mount(64'd8192, 1'b0);
        do_xfer(1'b1, 32'd3, 1'b0);
        check("restart_strobes", d_cap, 256);
        check("restart_data", d_bad, 0);

        ack_en = 1'b0;
        do_xfer(1'b1, 32'd3, 1'b1);
        check("tmo_strobes", d_cap, 256);
        check("tmo_zero", d_bad, 0);
        check("tmo_st_rd", d_str, 1024);
        ack_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
